// File: rtl/muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer bundle: request, stall/done status, HI/LO.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // EX stage / pipeline control side
    modport master (
        output start, funct, src_a, src_b,
        input  stall, done, hi, lo
    );

    // sequencer side
    modport slave (
        input  start, funct, src_a, src_b,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULTU/DIVU sequencer: one shift/add-subtract step per cycle, HI/LO result
// registers, pipeline stall while an operation is accepted or running.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [5:0]    FN_MULTU  = 6'd25;
    localparam logic [5:0]    FN_DIVU   = 6'd27;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplr_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mplr_d;
    logic [WIDTH:0]   div_t;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    logic is_mul;
    logic is_div;

    assign is_mul = bus.funct == FN_MULTU;
    assign is_div = bus.funct == FN_DIVU;

    // One multiply step and one restoring-divide step, computed from the current registers
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        // carry of the add becomes acc's top bit, low bit of the sum shifts into mplr
        acc_d   = mul_sum[WIDTH:1];
        mplr_d  = {mul_sum[0], mplr_q[WIDTH-1:1]};

        div_t = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
        if (!div_t[WIDTH]) begin
            rem_d = div_t[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sequencer FSM; HI/LO and done are loaded on the edge entering DONE so the
    // new result and the done pulse are both visible during the DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && is_mul) begin
                        acc_q   <= '0;
                        mcand_q <= bus.src_a;
                        mplr_q  <= bus.src_b;
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end else if (bus.start && is_div) begin
                        if (bus.src_b != '0) begin
                            rem_q   <= '0;
                            quo_q   <= bus.src_a;
                            dvsr_q  <= bus.src_b;
                            cnt_q   <= '0;
                            state_q <= S_DIV;
                        end else begin
                            hi_q    <= bus.src_a;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        hi_q    <= acc_d;
                        lo_q    <= mplr_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        hi_q    <= rem_d;
                        lo_q    <= quo_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall = (state_q == S_MUL) || (state_q == S_DIV) ||
                       ((state_q == S_IDLE) && bus.start && (is_mul || is_div));
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: MULTU/DIVU results, latency, stall window,
// divide-by-zero, async reset mid-operation, ignored funct and held start.
module tb_muldiv_seq;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for cycle T, then watch up to 40 cycles.
    // hold keeps start asserted until the done pulse has been seen.
    task automatic run_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold,
                          output int stall_t, output int lat, output int stall_cyc,
                          output int done_cnt, output logic [W-1:0] hi, output logic [W-1:0] lo);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.funct = fn;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        stall_t   = int'(bus.stall);
        lat       = -1;
        stall_cyc = 0;
        done_cnt  = 0;
        hi        = '0;
        lo        = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!hold || done_cnt > 0) bus.start = 1'b0;
            @(negedge clk);
            if (bus.stall) stall_cyc++;
            if (bus.done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k;
                    hi  = bus.hi;
                    lo  = bus.lo;
                end
            end
        end
        bus.start = 1'b0;
    endtask

    // Accept a full-length operation and compare everything observable
    task automatic long_op(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit hold,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int st, lat, sc, dc;
        logic [W-1:0] h, l;
        run_op(fn, a, b, hold, st, lat, sc, dc, h, l);
        check_eq({tag, "_stallT"}, 64'(st), 64'd1);
        check_eq({tag, "_latency"}, 64'(lat), 64'd33);
        check_eq({tag, "_stall_cycles"}, 64'(sc), 64'd32);
        check_eq({tag, "_done_pulses"}, 64'(dc), 64'd1);
        check_eq({tag, "_hi"}, 64'(h), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(l), 64'(exp_lo));
    endtask

    initial begin
        int st, lat, sc, dc;
        logic [W-1:0] h, l;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.src_a = '0;
        bus.src_b = '0;

        repeat (2) @(negedge clk);
        check_eq("reset_stall", 64'(bus.stall), 64'd0);
        check_eq("reset_done", 64'(bus.done), 64'd0);
        check_eq("reset_hi", 64'(bus.hi), 64'd0);
        check_eq("reset_lo", 64'(bus.lo), 64'd0);
        #2 rst = 1'b0;

        long_op("mul_7x6", 6'd25, 32'd7, 32'd6, 1'b0, 32'd0, 32'd42);
        long_op("mul_max", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        long_op("mul_2^31x2", 6'd25, 32'h80000000, 32'd2, 1'b0, 32'd1, 32'd0);
        long_op("div_100_7", 6'd27, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        long_op("div_5_9", 6'd27, 32'd5, 32'd9, 1'b0, 32'd5, 32'd0);
        long_op("div_max_1", 6'd27, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 32'hFFFFFFFF);
        long_op("div_max_max", 6'd27, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd1);

        // divide by zero completes in one cycle
        run_op(6'd27, 32'd1234, 32'd0, 1'b0, st, lat, sc, dc, h, l);
        check_eq("div0_stallT", 64'(st), 64'd1);
        check_eq("div0_latency", 64'(lat), 64'd1);
        check_eq("div0_stall_cycles", 64'(sc), 64'd0);
        check_eq("div0_done_pulses", 64'(dc), 64'd1);
        check_eq("div0_hi", 64'(h), 64'd1234);
        check_eq("div0_lo", 64'(l), 64'hFFFFFFFF);

        // async reset at step 10 of a multiply; HI/LO currently hold the div0 result
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.funct = 6'd25;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd1000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check_eq("pre_rst_stall", 64'(bus.stall), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_stall", 64'(bus.stall), 64'd0);
        check_eq("rst_mid_done", 64'(bus.done), 64'd0);
        check_eq("rst_mid_hi", 64'(bus.hi), 64'd0);
        check_eq("rst_mid_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        long_op("mul_3x3", 6'd25, 32'd3, 32'd3, 1'b0, 32'd0, 32'd9);

        // non-mul/div funct is ignored; HI/LO keep 0/9
        run_op(6'd32, 32'd11, 32'd22, 1'b0, st, lat, sc, dc, h, l);
        check_eq("add_stallT", 64'(st), 64'd0);
        check_eq("add_stall_cycles", 64'(sc), 64'd0);
        check_eq("add_done_pulses", 64'(dc), 64'd0);
        check_eq("add_hi_kept", 64'(bus.hi), 64'd0);
        check_eq("add_lo_kept", 64'(bus.lo), 64'd9);

        // start held through the whole multiply
        long_op("mul_held", 6'd25, 32'd12, 32'd12, 1'b1, 32'd0, 32'd144);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
